// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle between the two issue front ends, the shared logic unit
// and the response consumer of logic_unit_arbiter.
//   req0_*/req1_* : requester valid/ready handshake with opcode and operands
//   lu_*          : operands/opcode driven to the shared unit, lu_s its result
//   resp_*        : result handshake back to the owning requester
// Modports: slave = arbiter side, master = environment side.
interface logic_unit_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] lu_a;
    logic [WIDTH-1:0] lu_b;
    logic [1:0]       lu_ctrl;
    logic [WIDTH-1:0] lu_s;
    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             resp_ready;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  lu_s, resp_ready,
        output req0_ready, req1_ready,
        output lu_a, lu_b, lu_ctrl,
        output resp_valid, resp_id, resp_data
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output lu_s, resp_ready,
        input  req0_ready, req1_ready,
        input  lu_a, lu_b, lu_ctrl,
        input  resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Shares one combinational AND/OR/NOT/NAND unit between two requesters.
// Accepts one request at a time in IDLE, drives the unit from registered
// operands in EXEC, captures the result and holds it in RESP until consumed.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : logic_unit_arbiter_if.slave (requests, shared unit, response)
// Build option: LOGIC_ARB_RR_EN selects round-robin arbitration; when
// undefined, requester 0 has fixed priority under contention.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    logic_unit_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             pref;
    logic             sel;
    logic             fire;
    logic             ready0;
    logic             ready1;
    logic [WIDTH-1:0] lu_a_q;
    logic [WIDTH-1:0] lu_b_q;
    logic [1:0]       lu_ctrl_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_id_q;
    logic             resp_valid_q;

`ifdef LOGIC_ARB_RR_EN
    logic rr_ptr;

    // Preferred requester flips to the other one after every accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (fire) begin
            rr_ptr <= ~sel;
        end
    end

    assign pref = rr_ptr;
`else
    assign pref = 1'b0;
`endif

    // Under contention the preferred requester wins; otherwise whoever is valid.
    assign sel  = (bus.req0_valid & bus.req1_valid) ? pref : bus.req1_valid;
    assign fire = ready0 | ready1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fire) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (bus.resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Ready decode; held low while reset is asserted.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (rst_n && (state == IDLE)) begin
            ready0 = bus.req0_valid & ~sel;
            ready1 = bus.req1_valid & sel;
        end
    end

    // Operand latch on accept, result capture in EXEC, response flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_a_q       <= '0;
            lu_b_q       <= '0;
            lu_ctrl_q    <= 2'b00;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            if (fire) begin
                lu_a_q    <= sel ? bus.req1_a  : bus.req0_a;
                lu_b_q    <= sel ? bus.req1_b  : bus.req0_b;
                lu_ctrl_q <= sel ? bus.req1_op : bus.req0_op;
                resp_id_q <= sel;
            end
            if (state == EXEC) begin
                resp_data_q <= bus.lu_s;
            end
            resp_valid_q <= (state_nx == RESP);
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.lu_a       = lu_a_q;
    assign bus.lu_b       = lu_b_q;
    assign bus.lu_ctrl    = lu_ctrl_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed requests push the
// expected {id, data} into a queue; a monitor pops it on each completed
// response. Cycle-specific checks are made inline by the stimulus.
module tb_logic_unit_arbiter;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   done;
    logic [8:0] exp_q[$];

    logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference shared logic unit.
    always_comb begin
        case (bus.lu_ctrl)
            2'b00:   bus.lu_s = bus.lu_a & bus.lu_b;
            2'b01:   bus.lu_s = bus.lu_a | bus.lu_b;
            2'b10:   bus.lu_s = ~bus.lu_a;
            default: bus.lu_s = ~(bus.lu_a & bus.lu_b);
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic set_req(input bit id, input bit v, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Present one request, wait for its accept, push the expected response.
    task automatic issue(input bit id, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        set_req(id, 1'b1, op, a, b);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("accept_timeout");
        else exp_q.push_back({id, exp});
        @(posedge clk); #1;
        set_req(id, 1'b0, 2'b00, 8'h00, 8'h00);
    endtask

    // Wait until every pushed expectation has been consumed.
    task automatic drain();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("drain_timeout");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done   = 1'b0;
        rst_n  = 1'b0;
        set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
        bus.resp_ready = 1'b1;

        fork
            // Monitor: every completed response must match the queue head.
            begin
                while (!done) begin
                    @(negedge clk);
                    if (rst_n && bus.resp_valid && bus.resp_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_resp actual=%0h required=none",
                                     {bus.resp_id, bus.resp_data});
                        end else begin
                            logic [8:0] e;
                            e = exp_q.pop_front();
                            check("resp_id", 32'(bus.resp_id), 32'(e[8]));
                            check("resp_data", 32'(bus.resp_data), 32'(e[7:0]));
                        end
                    end
                end
            end
            // Stimulus.
            begin
                // Reset state, with a valid present to confirm ready is gated.
                repeat (2) @(posedge clk);
                #1 bus.req0_valid = 1'b1;
                @(negedge clk);
                check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
                check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
                check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
                check("rst_resp_id", 32'(bus.resp_id), 32'd0);
                check("rst_resp_data", 32'(bus.resp_data), 32'd0);
                check("rst_lu_a", 32'(bus.lu_a), 32'd0);
                check("rst_lu_b", 32'(bus.lu_b), 32'd0);
                check("rst_lu_ctrl", 32'(bus.lu_ctrl), 32'd0);
                bus.req0_valid = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;

                // Single op with cycle-exact timing.
                @(posedge clk); #1;
                set_req(1'b0, 1'b1, 2'b00, 8'hF0, 8'h3C);
                @(negedge clk);
                check("c0_req0_ready", 32'(bus.req0_ready), 32'd1);
                check("c0_req1_ready", 32'(bus.req1_ready), 32'd0);
                exp_q.push_back({1'b0, 8'h30});
                @(posedge clk); #1;
                set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
                @(negedge clk);
                check("c1_lu_ctrl", 32'(bus.lu_ctrl), 32'd0);
                check("c1_lu_a", 32'(bus.lu_a), 32'hF0);
                check("c1_lu_b", 32'(bus.lu_b), 32'h3C);
                check("c1_resp_valid", 32'(bus.resp_valid), 32'd0);
                @(negedge clk);
                check("c2_resp_valid", 32'(bus.resp_valid), 32'd1);
                check("c2_resp_id", 32'(bus.resp_id), 32'd0);
                check("c2_resp_data", 32'(bus.resp_data), 32'h30);
                drain();

                // All opcodes from requester 1.
                issue(1'b1, 2'b00, 8'hA5, 8'h0F, 8'h05); drain();
                issue(1'b1, 2'b01, 8'hA5, 8'h0F, 8'hAF); drain();
                issue(1'b1, 2'b10, 8'hA5, 8'h0F, 8'h5A); drain();
                issue(1'b1, 2'b11, 8'hA5, 8'h0F, 8'hFA); drain();

                // Contention: both valid for four accepts.
`ifdef LOGIC_ARB_RR_EN
                exp_q.push_back({1'b0, 8'h11});
                exp_q.push_back({1'b1, 8'h22});
                exp_q.push_back({1'b0, 8'h11});
                exp_q.push_back({1'b1, 8'h22});
`else
                repeat (4) exp_q.push_back({1'b0, 8'h11});
`endif
                @(posedge clk); #1;
                set_req(1'b0, 1'b1, 2'b00, 8'hFF, 8'h11);
                set_req(1'b1, 1'b1, 2'b01, 8'h00, 8'h22);
                begin
                    int n;
                    n = 0;
                    for (int i = 0; i < 100 && n < 4; i++) begin
                        @(negedge clk);
                        if ((bus.req0_valid && bus.req0_ready) ||
                            (bus.req1_valid && bus.req1_ready)) n++;
                    end
                    if (n < 4) fail("contention_timeout");
                end
                @(posedge clk); #1;
                set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
                set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
                drain();

                // Backpressure in RESP with req1 pending.
                issue(1'b0, 2'b01, 8'h0F, 8'hF0, 8'hFF);
                bus.resp_ready = 1'b0;
                set_req(1'b1, 1'b1, 2'b00, 8'hAA, 8'h0F);
                begin
                    bit got;
                    got = 1'b0;
                    for (int i = 0; i < 10; i++) begin
                        @(negedge clk);
                        if (bus.resp_valid === 1'b1) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    if (!got) fail("bp_resp_timeout");
                end
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
                    check("bp_resp_data", 32'(bus.resp_data), 32'hFF);
                    check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
                end
                @(posedge clk); #1 bus.resp_ready = 1'b1;
                @(negedge clk);
                check("bp_complete_req1_ready", 32'(bus.req1_ready), 32'd0);
                @(negedge clk);
                check("bp_next_req1_ready", 32'(bus.req1_ready), 32'd1);
                if (bus.req1_ready === 1'b1) exp_q.push_back({1'b1, 8'h0A});
                @(posedge clk); #1;
                set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
                drain();

                // Reset during EXEC abandons the operation.
                @(posedge clk); #1;
                set_req(1'b0, 1'b1, 2'b00, 8'h77, 8'h33);
                @(negedge clk);
                check("rx_req0_ready", 32'(bus.req0_ready), 32'd1);
                @(posedge clk); #1;
                set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
                rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
                @(negedge clk);
                check("rx_resp_valid", 32'(bus.resp_valid), 32'd0);
                check("rx_resp_id", 32'(bus.resp_id), 32'd0);
                check("rx_resp_data", 32'(bus.resp_data), 32'd0);
                check("rx_lu_a", 32'(bus.lu_a), 32'd0);
                check("rx_lu_b", 32'(bus.lu_b), 32'd0);
                check("rx_lu_ctrl", 32'(bus.lu_ctrl), 32'd0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("rx_no_resp", 32'(bus.resp_valid), 32'd0);
                end
                issue(1'b1, 2'b11, 8'hF0, 8'h3C, 8'hCF);
                drain();

                // Idle hold after an op with a=0x12.
                issue(1'b0, 2'b00, 8'h12, 8'h34, 8'h10);
                drain();
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("idle_lu_a", 32'(bus.lu_a), 32'h12);
                    check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
                end

                done = 1'b1;
            end
        join

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expect actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
